port_uart_tx: RTL and testbench
===============================

PORT_UART_TX -- requirements
Module: port_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per serial bit (legal range 2..255).
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, byte entries in the transmit FIFO (power of two, 2..16).
REQ-003 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port wr_en, input, 1, write strobe from the processor write-back stage (out_ld_Wb).
REQ-006 SHALL have port wr_data, input, 8, byte to send (Out_port value).
REQ-007 SHALL have port hlt_in, input, 1, processor HLT flag.
REQ-008 SHALL have port tx, output, 1, serial line (8N1, idle high).
REQ-009 SHALL have port busy, output, 1, FIFO non-empty or frame in progress.
REQ-010 SHALL have port full, output, 1, FIFO holds FIFO_DEPTH bytes.
REQ-011 SHALL have port overflow, output, 1, sticky flag: a write was dropped.
REQ-012 SHALL have port drained, output, 1, hlt_in high and busy low.

Function
REQ-013 SHALL push wr_data into the FIFO on a rising edge where wr_en=1 and full=0.
REQ-014 SHALL drop the write and set overflow on a rising edge where wr_en=1 and full=1, even if a pop occurs on the same edge (full is evaluated on the pre-edge count).
REQ-015 SHALL keep overflow at 1 until reset.
REQ-016 SHALL treat FIFO pointers as modulo FIFO_DEPTH, wrapping with no gap, with count in 0..FIFO_DEPTH.
REQ-017 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on a simultaneous push and pop.
REQ-018 SHALL implement FSM states IDLE, START, DATA, STOP, with a bit-period counter 0..CLKS_PER_BIT-1 and a bit index 0..7.
REQ-019 SHALL, in IDLE with count!=0, pop the FIFO head into the shift register, enter START, and reset the bit counter on that edge.
REQ-020 SHALL drive tx=1 in IDLE, tx=0 in START, tx=shift[0] in DATA (LSB first), and tx=1 in STOP.
REQ-021 SHALL hold each state for exactly CLKS_PER_BIT cycles per bit: START 1 bit, DATA 8 bits, STOP 1 bit, giving a frame of 10*CLKS_PER_BIT cycles.
REQ-022 SHALL, at the end of STOP with count!=0, pop and enter START directly (no idle cycle); with count=0, it SHALL enter IDLE.
REQ-023 SHALL drive tx from a register (glitch-free), with tx first falling on the edge after the edge on which the byte was written into an empty FIFO while the FSM was in IDLE.
REQ-024 SHALL compute busy as (state!=IDLE) or (count!=0), and full as count==FIFO_DEPTH, both combinational from registers.
REQ-025 SHALL assert drained only when hlt_in=1 and busy=0, and SHALL NOT let hlt_in stop acceptance or transmission.

Reset
REQ-026 SHALL, while rst=0, immediately force tx=1, busy=0, full=0, overflow=0, drained=hlt_in, state=IDLE, FIFO empty, and counters 0.
REQ-027 SHALL abandon any frame in progress when reset is asserted mid-frame and not resume it after release; FIFO contents SHALL be discarded.
REQ-028 SHALL accept writes on the first rising edge after rst rises.

Verification
REQ-029 Single byte, CLKS_PER_BIT=4: write 0xA5 -> tx = 0,1,0,1,0,0,1,0,1,1, each level 4 cycles, 40 cycles total; busy falls on the edge ending STOP.
REQ-030 Burst, CLKS_PER_BIT=4, DEPTH=4: wr_en on 6 consecutive edges with 0x01..0x06 -> 0x01..0x05 transmitted back-to-back with no idle gap, 0x06 dropped, overflow=1, full high after the 5th edge.
REQ-031 Wrap-around: 12 bytes 0x10..0x1B written as space frees -> all 12 received in order, overflow=0.
REQ-032 Reset mid-frame: assert rst=0 during DATA bit 3 with 2 bytes queued -> tx=1 and busy=0 immediately; after release tx stays 1 until a new write.
REQ-033 Halt drain: hlt_in=1 while 2 bytes are pending -> drained=0 until the second STOP ends, then drained=1 and tx=1.
REQ-034 Simultaneous: FIFO full, FSM pops at STOP end on the same edge as wr_en -> write dropped, overflow=1, count=DEPTH-1.

Source files
------------

// File: rtl/port_uart_tx.sv
// Byte-wide transmit port for a small processor: a write-back store feeds a
// FIFO that drains through an 8N1 serializer with a registered, glitch-free tx.
module port_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       hlt_in,
  output logic       tx,
  output logic       busy,
  output logic       full,
  output logic       overflow,
  output logic       drained
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  logic [1:0]    r_state;
  logic [7:0]    r_clk_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_tx;

  logic          w_full;
  logic          w_nempty;
  logic          w_push;
  logic          w_pop;
  logic          w_bit_end;
  logic [7:0]    w_head;

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_nempty  = (r_count != '0);
  assign w_head    = r_mem[r_rptr];
  assign w_bit_end = (r_clk_cnt == 8'(CLKS_PER_BIT - 1));

  // Full is judged on the pre-edge count, so a pop on the same edge never
  // rescues a write that arrives while the FIFO is full.
  assign w_push = wr_en & ~w_full;
  assign w_pop  = w_nempty & ((r_state == S_IDLE) |
                              ((r_state == S_STOP) & w_bit_end));

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (wr_en && w_full) r_overflow <= 1'b1;
    end
  end

  // r_tx is loaded with the level of the state being entered, so the line
  // changes on the same edge as the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_clk_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_nempty) begin
            r_state   <= S_START;
            r_clk_cnt <= '0;
            r_shift   <= w_head;
            r_tx      <= 1'b0;
          end
        end
        S_START: begin
          if (w_bit_end) begin
            r_state   <= S_DATA;
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_tx      <= r_shift[0];
          end else begin
            r_clk_cnt <= r_clk_cnt + 8'd1;
          end
        end
        S_DATA: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (r_bit_idx == 3'd7) begin
              r_state <= S_STOP;
              r_tx    <= 1'b1;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_shift   <= {1'b0, r_shift[7:1]};
              r_tx      <= r_shift[1];
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 8'd1;
          end
        end
        S_STOP: begin
          if (w_bit_end) begin
            r_clk_cnt <= '0;
            if (w_nempty) begin
              r_state <= S_START;
              r_shift <= w_head;
              r_tx    <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_tx    <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 8'd1;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_clk_cnt <= '0;
          r_tx      <= 1'b1;
        end
      endcase
    end
  end

  assign tx       = r_tx;
  assign busy     = (r_state != S_IDLE) | w_nempty;
  assign full     = w_full;
  assign overflow = r_overflow;
  assign drained  = hlt_in & ~busy;

endmodule

// File: tb/tb_port_uart_tx.sv
// Randomized + directed bench for port_uart_tx: frame-level reference model,
// a scoreboard of accepted bytes, and a serial receiver that checks them.
module tb_port_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       hlt_in = 1'b0;
  logic       tx, busy, full, overflow, drained;

  int n_cmp = 0;
  int n_err = 0;

  // reference model: pending bytes, cycles left in the current frame
  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  int         m_rem = 0;
  logic [7:0] m_cur = 8'h00;
  logic       m_ovf = 1'b0;
  logic       chk_en = 1'b0;

  port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .hlt_in(hlt_in),
    .tx(tx), .busy(busy), .full(full), .overflow(overflow), .drained(drained)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err < 40) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: a frame lasts FRAME cycles; a new one starts whenever bytes are
  // pending and the line is idle or on the last cycle of the previous frame
  initial forever begin
    int s, r;
    @(posedge clk or negedge rst);
    if (!rst) begin
      mq.delete(); exp_q.delete(); m_rem = 0; m_ovf = 1'b0;
    end else begin
      s = mq.size(); r = m_rem;
      if (s != 0 && r <= 1) begin
        m_cur = mq.pop_front(); m_rem = FRAME;
      end else if (r > 0) m_rem = r - 1;
      if (wr_en) begin
        if (s == DEPTH) m_ovf = 1'b1;
        else begin mq.push_back(wr_data); exp_q.push_back(wr_data); end
      end
    end
  end

  // per-cycle flag and line-level check against the model
  initial forever begin
    logic       e_busy, e_tx;
    logic [9:0] fr;
    @(negedge clk);
    if (chk_en) begin
      e_busy = (m_rem != 0) || (mq.size() != 0);
      if (m_rem == 0) e_tx = 1'b1;
      else begin
        fr = {1'b1, m_cur, 1'b0};
        e_tx = fr[(FRAME - m_rem) / CPB];
      end
      chk("tx", 32'(tx), 32'(e_tx));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("full", 32'(full), 32'(mq.size() == DEPTH));
      chk("overflow", 32'(overflow), 32'(m_ovf));
      chk("drained", 32'(drained), 32'(hlt_in && !e_busy));
    end
  end

  // serial receiver: decodes frames and pops the scoreboard
  initial forever begin
    logic       act;
    int         cnt;
    logic [9:0] bits;
    logic [7:0] exp_b;
    act = 1'b0; cnt = 0; bits = '0;
    forever begin
      @(negedge clk);
      if (!rst) act = 1'b0;
      else if (!act) begin
        if (tx === 1'b0) begin act = 1'b1; cnt = 0; end
      end else cnt++;
      if (act && rst && (cnt % CPB) == CPB / 2) begin
        bits[cnt / CPB] = tx;
        if (cnt / CPB == 9) begin
          act = 1'b0;
          chk("rx_start", 32'(bits[0]), 32'd0);
          chk("rx_stop", 32'(bits[9]), 32'd1);
          if (exp_q.size() == 0) chk("rx_unexpected", 32'(bits[8:1]), 32'hFFFF_FFFF);
          else begin
            exp_b = exp_q.pop_front();
            chk("rx_byte", 32'(bits[8:1]), 32'(exp_b));
          end
        end
      end
    end
  end

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic idle_wait();
    int n;
    n = 0;
    while ((m_rem != 0 || mq.size() != 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    chk("idle_timeout", 32'(n >= 3000), 32'd0);
    repeat (CPB) @(negedge clk);
  endtask

  task automatic rst_pulse();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    int i, n;
    repeat (3) @(negedge clk);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk_en = 1'b1;
    rst = 1'b1;
    @(negedge clk);

    // single byte
    wr(8'hA5);
    idle_wait();

    // burst of six into a depth-4 FIFO
    wr_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      wr_data = 8'(k);
      @(negedge clk);
    end
    wr_en = 1'b0;
    chk("burst_ovf", 32'(overflow), 32'd1);
    idle_wait();

    // wrap-around: 12 bytes as space frees
    rst_pulse();
    i = 0; n = 0;
    while (i < 12 && n < 3000) begin
      if (mq.size() < DEPTH) begin
        wr_en = 1'b1; wr_data = 8'(8'h10 + i); i++;
      end else wr_en = 1'b0;
      @(negedge clk); n++;
    end
    wr_en = 1'b0;
    chk("wrap_written", 32'(i), 32'd12);
    idle_wait();
    chk("wrap_ovf", 32'(overflow), 32'd0);

    // reset during data bit 3
    wr(8'h3C); wr(8'hC3); wr(8'h5A);
    repeat (CPB * 4 + CPB / 2) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_tx", 32'(tx), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_rst_tx", 32'(tx), 32'd1);

    // halt drain
    hlt_in = 1'b1;
    wr(8'h81); wr(8'h7E);
    chk("drain_pending", 32'(drained), 32'd0);
    idle_wait();
    chk("drain_done", 32'(drained), 32'd1);
    hlt_in = 1'b0;

    // write on the same edge the full FIFO pops
    for (int k = 0; k < 5; k++) wr(8'(8'h90 + k));
    n = 0;
    while (!(m_rem == 1 && mq.size() == DEPTH) && n < 200) begin
      @(negedge clk); n++;
    end
    chk("simul_reach", 32'(n < 200), 32'd1);
    wr(8'hEE);
    chk("simul_ovf", 32'(overflow), 32'd1);
    chk("simul_full", 32'(full), 32'd0);
    idle_wait();

    // randomized traffic
    rst_pulse();
    for (int c = 0; c < 2000; c++) begin
      if (c % 100 == 0) hlt_in = 1'($urandom_range(0, 1));
      wr_en   = ((c / 250) % 2 == 0) ? ($urandom_range(0, 47) == 0)
                                     : ($urandom_range(0, 3) == 0);
      wr_data = 8'($urandom);
      @(negedge clk);
    end
    wr_en = 1'b0;
    idle_wait();
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
